// File: rtl/gray_count_monitor.sv
// gray_count_monitor: decodes a sampled Gray count, checks each advance, flags wraps/terminal count/illegal steps.
// Optional GRAY_MON_ERR_CNT_EN builds the saturating error counter; otherwise err_cnt_o is tied to 0.
`default_nettype none

module gray_count_monitor #(
  parameter int BIT_SIZE  = 4,
  parameter int INCREMENT = 1,
  parameter int SIZE      = 10,
  parameter int ERR_W     = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [BIT_SIZE-1:0] gray_i,
  input  logic                en_i,
  input  logic                clr_err_i,
  output logic [BIT_SIZE-1:0] bin_o,
  output logic                bin_valid_o,
  output logic                wrap_o,
  output logic                term_o,
  output logic                step_err_o,
  output logic                fault_o,
  output logic [ERR_W-1:0]    err_cnt_o
);

  localparam logic [BIT_SIZE-1:0] STEP     = BIT_SIZE'(INCREMENT);
  localparam logic [BIT_SIZE-1:0] TERM_VAL = BIT_SIZE'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BIT_SIZE-1:0] b_new;
  logic [BIT_SIZE-1:0] delta;
  logic                checking;
  logic                stall;
  logic                legal;
  logic                bad_step;

  always_comb begin
    b_new = '0;
    for (int i = 0; i < BIT_SIZE; i++) begin
      b_new[i] = ^(gray_i >> i);
    end
  end

  assign delta    = b_new - bin_o;
  assign checking = en_i && (state != IDLE);
  assign stall    = (delta == '0);
  assign legal    = !stall && (delta == STEP);
  assign bad_step = checking && !stall && !legal;

  // A clear is applied before the step check, so an illegal step on the same edge re-enters FAULT.
  always_comb begin
    state_next = state;
    if (clr_err_i && state == FAULT) begin
      state_next = TRACK;
    end
    if (en_i && state == IDLE) begin
      state_next = TRACK;
    end else if (bad_step) begin
      state_next = FAULT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bin_o       <= '0;
      bin_valid_o <= 1'b0;
      wrap_o      <= 1'b0;
      term_o      <= 1'b0;
      step_err_o  <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      state      <= state_next;
      fault_o    <= (state_next == FAULT);
      wrap_o     <= 1'b0;
      term_o     <= 1'b0;
      step_err_o <= 1'b0;
      if (en_i) begin
        bin_o <= b_new;
        if (state == IDLE) begin
          bin_valid_o <= 1'b1;
          term_o      <= (b_new == TERM_VAL);
        end else if (!stall) begin
          term_o     <= (b_new == TERM_VAL);
          wrap_o     <= legal && (b_new < bin_o);
          step_err_o <= !legal;
        end
      end
    end
  end

`ifdef GRAY_MON_ERR_CNT_EN
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  logic [ERR_W-1:0] err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt <= '0;
    end else if (bad_step) begin
      if (clr_err_i) begin
        err_cnt <= ERR_W'(1);
      end else if (err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end else if (clr_err_i) begin
      err_cnt <= '0;
    end
  end

  assign err_cnt_o = err_cnt;
`else
  assign err_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_count_monitor.sv
// Directed table-driven bench for gray_count_monitor (BIT_SIZE=4, INCREMENT=1, SIZE=10, ERR_W=2).
`default_nettype none

module tb_gray_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray;
  logic       en;
  logic       clr;
  logic [3:0] bin;
  logic       valid;
  logic       wrap;
  logic       term;
  logic       serr;
  logic       fault;
  logic [1:0] err_cnt;

  int checks = 0;
  int passed = 0;

`ifdef GRAY_MON_ERR_CNT_EN
  localparam bit HAS_ERR = 1'b1;
`else
  localparam bit HAS_ERR = 1'b0;
`endif

  gray_count_monitor #(
    .BIT_SIZE (4),
    .INCREMENT(1),
    .SIZE     (10),
    .ERR_W    (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .gray_i     (gray),
    .en_i       (en),
    .clr_err_i  (clr),
    .bin_o      (bin),
    .bin_valid_o(valid),
    .wrap_o     (wrap),
    .term_o     (term),
    .step_err_o (serr),
    .fault_o    (fault),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] gray;
    logic [3:0] bin;
    logic       valid;
    logic       wrap;
    logic       term;
    logic       serr;
    logic       fault;
    logic [1:0] err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s @vec %0d: got %0d expected %0d", name, idx, act, exp);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst  = v.rst;
    en   = v.en;
    clr  = v.clr;
    gray = v.gray;
    @(posedge clk);
    #1;
    chk("bin_o", idx, int'(bin), int'(v.bin));
    chk("bin_valid_o", idx, int'(valid), int'(v.valid));
    chk("wrap_o", idx, int'(wrap), int'(v.wrap));
    chk("term_o", idx, int'(term), int'(v.term));
    chk("step_err_o", idx, int'(serr), int'(v.serr));
    chk("fault_o", idx, int'(fault), int'(v.fault));
    chk("err_cnt_o", idx, int'(err_cnt), HAS_ERR ? int'(v.err) : 0);
  endtask

  task automatic add(input logic r, input logic e, input logic c, input logic [3:0] g,
                     input logic [3:0] b, input logic vl, input logic w, input logic t,
                     input logic s, input logic f, input logic [1:0] ec);
    vec_t v;
    v = '{rst: r, en: e, clr: c, gray: g, bin: b, valid: vl, wrap: w, term: t,
          serr: s, fault: f, err: ec};
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; gray = 4'd0;

    //  rst en clr gray | bin vld wrp trm ser flt err
    add(1, 0, 0, 4'd0,   4'd0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd0,   4'd0,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd1,   4'd1,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd3,   4'd2,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd2,   4'd3,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd6,   4'd4,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd7,   4'd5,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd5,   4'd6,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd4,   4'd7,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd12,  4'd8,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd13,  4'd9,  1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd15,  4'd9,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd13,  4'd9,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd15,  4'd10, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd14,  4'd11, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd10,  4'd12, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd11,  4'd13, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd9,   4'd14, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd8,   4'd15, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd0,   4'd0,  1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 4'd1,   4'd1,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd2,   4'd3,  1, 0, 0, 1, 1, 1);
    add(0, 1, 0, 4'd2,   4'd3,  1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 4'd6,   4'd4,  1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 4'd0,   4'd0,  1, 0, 0, 1, 1, 2);
    add(0, 1, 0, 4'd3,   4'd2,  1, 0, 0, 1, 1, 3);
    add(0, 1, 0, 4'd15,  4'd10, 1, 0, 0, 1, 1, 3);
    add(0, 1, 0, 4'd1,   4'd1,  1, 0, 0, 1, 1, 3);
    add(0, 0, 1, 4'd9,   4'd1,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd12,  4'd8,  1, 0, 0, 1, 1, 1);
    add(0, 1, 1, 4'd4,   4'd7,  1, 0, 0, 1, 1, 1);
    add(0, 1, 1, 4'd12,  4'd8,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd0,   4'd0,  1, 0, 0, 1, 1, 1);
    add(0, 1, 0, 4'd3,   4'd2,  1, 0, 0, 1, 1, 2);
    add(1, 1, 0, 4'd5,   4'd0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd7,   4'd5,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd5,   4'd6,  1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4'd0,   4'd0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4'd13,  4'd0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd13,  4'd9,  1, 0, 1, 0, 0, 0);

    foreach (vecs[k]) apply(vecs[k], k);

    // Gray input wanders while the strobe is low: value and flags must hold.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en   = 1'b0;
      clr  = 1'b0;
      gray = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      chk("hold bin_o", 100 + i, int'(bin), 9);
      chk("hold pulses", 100 + i, int'({wrap, term, serr}), 0);
      chk("hold fault_o", 100 + i, int'(fault), 0);
    end

    // Resume with a legal step from the held value, then an illegal jump.
    @(negedge clk);
    en = 1'b1; gray = 4'd15;
    @(posedge clk);
    #1;
    chk("resume bin_o", 200, int'(bin), 10);
    chk("resume step_err_o", 200, int'(serr), 0);
    @(negedge clk);
    gray = 4'd4;
    @(posedge clk);
    #1;
    chk("jump bin_o", 201, int'(bin), 7);
    chk("jump step_err_o", 201, int'(serr), 1);
    chk("jump fault_o", 201, int'(fault), 1);
    chk("jump err_cnt_o", 201, int'(err_cnt), HAS_ERR ? 1 : 0);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("pulse end step_err_o", 202, int'(serr), 0);
    chk("sticky fault_o", 202, int'(fault), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
